// File: rtl/gauss_stream_3x3_if.sv
// Pixel stream bundle for the 3x3 blur: s_* carries raster input, m_* carries blurred output.
// master = the blur block side, slave = the source/sink environment side.
// Handshake is valid/ready on both streams; m_sof/m_eol qualify m_data while m_valid=1.
interface gauss_stream_3x3_if #(
    parameter int PW = 8
);
    logic          s_valid;
    logic          s_ready;
    logic [PW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [PW-1:0] m_data;
    logic          m_sof;
    logic          m_eol;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_sof, m_eol
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_sof, m_eol
    );
endinterface

// File: rtl/gauss_stream_3x3.sv
// Streaming 3x3 Gaussian blur (1-2-1 kernel, /16), valid-region output only; GAUSS_ROUND_EN selects round-half-up.
// Latency: output registered on the edge that accepts its emitting input pixel.
// Backpressure: single output register, s_ready = !m_valid || m_ready; all state frozen while stalled.
module gauss_stream_3x3 #(
    parameter int PW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    gauss_stream_3x3_if.master bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = PW + 4;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] lb1 [IMG_W];
    logic [PW-1:0] lb2 [IMG_W];

    // Window keeps the two older columns per row; the newest column is taken
    // live from the line buffers and s_data so the result is ready on accept.
    logic [PW-1:0] top_a, top_b, mid_a, mid_b, bot_a, bot_b;
    logic [PW-1:0] top_n, mid_n, bot_n;

    logic          m_valid_q;
    logic [PW-1:0] m_data_q;
    logic          m_sof_q, m_eol_q;

    logic          xfer, emit, last_col, last_row;
    logic [SW-1:0] sum, rsum;

    function automatic logic [SW-1:0] ext(input logic [PW-1:0] p);
        return {4'b0000, p};
    endfunction

    assign bus.s_ready = !m_valid_q || bus.m_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_sof   = m_sof_q;
    assign bus.m_eol   = m_eol_q;

    assign xfer     = bus.s_valid && bus.s_ready;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    assign emit     = xfer && (row >= RW'(2)) && (col >= CW'(2));

    assign top_n = lb2[col];
    assign mid_n = lb1[col];
    assign bot_n = bus.s_data;

    assign sum = ext(top_a) + (ext(top_b) << 1) + ext(top_n)
               + (ext(mid_a) << 1) + (ext(mid_b) << 2) + (ext(mid_n) << 1)
               + ext(bot_a) + (ext(bot_b) << 1) + ext(bot_n);

`ifdef GAUSS_ROUND_EN
    assign rsum = sum + SW'(8);
`else
    assign rsum = sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (xfer) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Buffers and window are never cleared: rows 0-1 and cols 0-1 never emit,
    // so stale contents are always overwritten before they reach an output.
    always_ff @(posedge clk) begin
        if (xfer) begin
            lb1[col] <= bus.s_data;
            lb2[col] <= lb1[col];
            top_a    <= top_b;
            top_b    <= top_n;
            mid_a    <= mid_b;
            mid_b    <= mid_n;
            bot_a    <= bot_b;
            bot_b    <= bot_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sof_q   <= 1'b0;
            m_eol_q   <= 1'b0;
        end else if (emit) begin
            m_valid_q <= 1'b1;
            m_data_q  <= rsum[PW+3:4];
            m_sof_q   <= (row == RW'(2)) && (col == CW'(2));
            m_eol_q   <= last_col;
        end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gauss_stream_3x3.sv
// Directed bench for gauss_stream_3x3 at 8x6, PW=8: constant, impulse, ramp with random
// handshakes, back-to-back frames and mid-frame reset, against hand-computed values.
module tb_gauss_stream_3x3;
    localparam int W = 8;
    localparam int H = 6;
    localparam int NOUT = (W - 2) * (H - 2);

`ifdef GAUSS_ROUND_EN
    localparam int IMP_C = 64;
    localparam int IMP_E = 32;
    localparam int IMP_D = 16;
`else
    localparam int IMP_C = 63;
    localparam int IMP_E = 31;
    localparam int IMP_D = 15;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eol;
    } out_t;

    logic clk;
    logic rst;
    gauss_stream_3x3_if #(.PW(8)) bus ();

    gauss_stream_3x3 #(.PW(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   pat   = 0;
    int   cval  = 0;
    bit   rnd_v = 0;
    bit   rnd_r = 0;
    bit   stall_chk = 0;
    bit   held = 0;
    out_t held_o;
    out_t got[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int i);
        int r, c;
        r = (i / W) % H;
        c = i % W;
        case (pat)
            0:       return 8'(cval);
            1:       return (r == 2 && c == 2) ? 8'd255 : 8'd0;
            default: return 8'(10 * r + c);
        endcase
    endfunction

    function automatic int imp_exp(input int r, input int c);
        int dr, dc;
        dr = (r > 2) ? r - 2 : 2 - r;
        dc = (c > 2) ? c - 2 : 2 - c;
        if (dr == 0 && dc == 0) return IMP_C;
        if (dr + dc == 1)       return IMP_E;
        if (dr == 1 && dc == 1) return IMP_D;
        return 0;
    endfunction

    always begin
        @(posedge clk);
        #1;
        bus.m_ready = rnd_r ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output capture and stall-stability checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready)
            got.push_back('{d: bus.m_data, sof: bus.m_sof, eol: bus.m_eol});
        if (stall_chk) begin
            if (held) begin
                chk("hold_vld", 32'(bus.m_valid), 32'd1);
                chk("hold_dat", 32'(bus.m_data), 32'(held_o.d));
                chk("hold_sof", 32'(bus.m_sof), 32'(held_o.sof));
                chk("hold_eol", 32'(bus.m_eol), 32'(held_o.eol));
            end
            held = bus.m_valid && !bus.m_ready;
            if (held) begin
                chk("stall_srdy", 32'(bus.s_ready), 32'd0);
                held_o = '{d: bus.m_data, sof: bus.m_sof, eol: bus.m_eol};
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic run(input int n);
        int i, cyc;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 5000) begin
            @(posedge clk);
            #1;
            if (rnd_v && $urandom_range(0, 2) == 0) begin
                bus.s_valid = 1'b0;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = pix(i);
            end
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) i++;
            cyc++;
        end
        if (i < n) chk("send_timeout", 32'(i), 32'(n));
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        int cyc;
        cyc = 0;
        while (got.size() < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        chk("out_count", 32'(got.size()), 32'(n));
    endtask

    task automatic check_ramp(input int n);
        int j, r, c;
        for (int k = 0; k < n && k < got.size(); k++) begin
            j = k % NOUT;
            r = j / (W - 2) + 1;
            c = j % (W - 2) + 1;
            chk("ramp_dat", 32'(got[k].d), 32'(10 * r + c));
            chk("ramp_sof", 32'(got[k].sof), 32'(j == 0));
            chk("ramp_eol", 32'(got[k].eol), 32'(c == W - 2));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mvalid", 32'(bus.m_valid), 32'd0);
        chk("rst_mdata", 32'(bus.m_data), 32'd0);
        chk("rst_msof", 32'(bus.m_sof), 32'd0);
        chk("rst_meol", 32'(bus.m_eol), 32'd0);
        chk("rst_sready", 32'(bus.s_ready), 32'd1);

        // Constant 100 frame at full throughput.
        pat = 0;
        cval = 100;
        got.delete();
        run(W * H);
        drain(NOUT);
        for (int k = 0; k < got.size(); k++) begin
            chk("const_dat", 32'(got[k].d), 32'd100);
            chk("const_sof", 32'(got[k].sof), 32'(k == 0));
            chk("const_eol", 32'(got[k].eol), 32'((k % 6) == 5));
        end

        // Single 255 impulse at (2,2).
        pat = 1;
        got.delete();
        run(W * H);
        drain(NOUT);
        for (int k = 0; k < got.size() && k < NOUT; k++)
            chk("imp_dat", 32'(got[k].d), 32'(imp_exp(k / 6 + 1, k % 6 + 1)));

        // Ramp with random s_valid and m_ready; a linear ramp blurs to itself.
        pat = 2;
        rnd_v = 1;
        rnd_r = 1;
        stall_chk = 1;
        got.delete();
        run(W * H);
        drain(NOUT);
        check_ramp(NOUT);

        // Two back-to-back ramp frames.
        got.delete();
        run(2 * W * H);
        drain(2 * NOUT);
        check_ramp(2 * NOUT);
        if (got.size() > NOUT) chk("frame2_sof", 32'(got[NOUT].sof), 32'd1);
        rnd_v = 0;
        rnd_r = 0;
        repeat (4) @(negedge clk);
        stall_chk = 0;

        // Mid-frame reset while an output is pending.
        pat = 0;
        cval = 77;
        run(20);
        chk("pre_rst_mvalid", 32'(bus.m_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_mvalid", 32'(bus.m_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        cval = 50;
        run(W * H);
        drain(NOUT);
        for (int k = 0; k < got.size(); k++) begin
            chk("post_rst_dat", 32'(got[k].d), 32'd50);
            chk("post_rst_sof", 32'(got[k].sof), 32'(k == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gauss_stream_3x3.md
# gauss_stream_3x3

Streaming 3x3 Gaussian blur (kernel 1-2-1 / 2-4-2 / 1-2-1, divide by 16) for raster-order pixel streams, with parametrised pixel width and frame size. The block buffers two image lines internally and builds each 3x3 window itself, so the upstream source delivers one pixel per transfer instead of nine. It sits between a pixel source (camera or frame reader) and downstream filter or sink stages on a valid/ready stream with full backpressure. It emits only fully covered ("valid-region") pixels: (IMG_W-2) x (IMG_H-2) outputs per frame.

## Interface
- PW, 8: pixel width in bits.
- IMG_W, 640: frame width in pixels (>= 3).
- IMG_H, 480: frame height in lines (>= 3).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block accepts the input pixel this cycle.
- s_data  in  PW  input pixel, raster order, frame-aligned from reset.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accepts the output pixel.
- m_data  out  PW  blurred pixel.
- m_sof  out  1  first output pixel of a frame.
- m_eol  out  1  last output pixel of an output line.

## Operation
- Input transfer: s_valid && s_ready. Output transfer: m_valid && m_ready.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) advance on each input transfer.
  - col wraps to 0 at IMG_W-1, and row increments at the same time.
  - At col=IMG_W-1, row=IMG_H-1, both wrap to 0, which starts the next frame with no gap.
- Line buffers: two IMG_W x PW memories hold rows r-1 and r-2. Each is read and written at index col on every input transfer.
- Window: three 3-column shift registers hold the rows r-2, r-1, r columns. They shift on input transfer only.
- Emit condition: the input transfer at (row>=2, col>=2) produces one output, centred at (row-1, col-1). No other input transfer produces an output.
- Arithmetic:
  - sum = Σ w·p, computed at width PW+4 (the maximum 16·(2^PW−1) plus the rounding term fits).
  - m_data = sum[PW+3:4] (truncate) unless rounding is configured; see Configuration.
- Flags:
  - m_sof=1 for the output centred at (1,1).
  - m_eol=1 for outputs centred at column IMG_W-2.
  - Both flags are 0 otherwise and are valid only while m_valid=1.
- Backpressure: s_ready = !m_valid || m_ready (single output register, no bubble at full throughput).
- Non-emitting input transfers (first two rows, first two columns of each row) are accepted whenever s_ready=1.
- Reset, including mid-frame:
  - col=0, row=0, m_valid=0, m_data=0, m_sof=0, m_eol=0, and s_ready=1 one cycle after reset is released (the output register is empty).
  - Line buffer and window contents are not cleared. They are never used before being overwritten, because rows 0-1 and cols 0-1 do not emit.
- s_data is sampled only on an input transfer. Input while s_valid=0 is ignored.

## Timing
- Latency: an output becomes m_valid=1 on the clock edge that accepts its emitting input pixel. It is visible the cycle after that transfer.
- Throughput: 1 pixel/cycle when s_valid=1 and m_ready=1 are held.
- While m_valid=1 && m_ready=0:
  - m_data, m_sof and m_eol hold stable.
  - s_ready=0, and no counter, buffer or window state changes.
- Simultaneous output transfer and emitting input transfer: the output register reloads with the new pixel in the same cycle, so m_valid stays 1.
- Output transfer with a non-emitting or no input transfer: m_valid goes to 0 on the next cycle.
- Line buffer: single-port read-before-write per index per cycle; it maps to one RAM per line.

## Configuration
- GAUSS_ROUND_EN defined: m_data = (sum + 8) >> 4, rounding half up. No saturation is needed because the maximum is 2^PW−1.
- GAUSS_ROUND_EN undefined: m_data = sum >> 4, truncating.
- Only m_data values change between the two builds. Ports, latency and handshake are identical.

## Test plan
All scenarios use IMG_W=8, IMG_H=6, PW=8.
- Constant frame, all pixels 100, m_ready=1 -> exactly 24 outputs, all 100. m_sof on the 1st output only. m_eol on outputs 6, 12, 18 and 24.
- Impulse: 255 at (2,2), all other pixels 0 -> expected outputs:
  - centre (2,2) = 63 (64 with GAUSS_ROUND_EN);
  - (1,2), (3,2), (2,1) and (2,3) = 31 (32);
  - diagonals (1,1), (1,3), (3,1) and (3,3) = 15 (16);
  - all other outputs 0.
- Ramp frame (pixel = 10·row + col), random s_valid and random m_ready -> output sequence matches the software model exactly.
  - No m_data/m_sof/m_eol change while stalled.
  - s_ready=0 whenever m_valid=1 && m_ready=0.
- Two back-to-back ramp frames -> 48 outputs, and the second frame's m_sof comes on the 25th output.
- Assert rst after 20 input transfers (with m_valid=1), then send a full constant-50 frame -> m_valid=0 immediately after reset. Then exactly 24 outputs of 50, with m_sof on the first.
